// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit shift register: hold, shift L/R, load, clear, saturating shift counter with word-done pulse.
// Define SHIFTREG_ROTATE_EN to enable rotate left/right (modes 100/101); otherwise those modes hold.
module shift_reg_univ #(
    parameter int unsigned          WIDTH   = 4,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [2:0]                    mode,
    input  logic                          d_l,
    input  logic                          d_r,
    input  logic [WIDTH-1:0]              p,
    output logic [WIDTH-1:0]              y,
    output logic                          so_l,
    output logic                          so_r,
    output logic [$clog2(WIDTH+1)-1:0]    cnt,
    output logic                          done
);

    localparam int unsigned CW      = $clog2(WIDTH+1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_LOAD  = 3'b011,
        MODE_ROTL  = 3'b100,
        MODE_ROTR  = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_t;

    mode_t            op;
    logic [WIDTH-1:0] y_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             done_nxt;
    logic             is_shift;

    assign op   = mode_t'(mode);
    assign so_l = y[WIDTH-1];
    assign so_r = y[0];

    always_comb begin
        y_nxt    = y;
        cnt_nxt  = cnt;
        done_nxt = 1'b0;
        is_shift = 1'b0;
        if (en) begin
            case (op)
                MODE_SHL: begin
                    y_nxt    = {y[WIDTH-2:0], d_l};
                    is_shift = 1'b1;
                end
                MODE_SHR: begin
                    y_nxt    = {d_r, y[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                MODE_LOAD: begin
                    y_nxt   = p;
                    cnt_nxt = '0;
                end
`ifdef SHIFTREG_ROTATE_EN
                MODE_ROTL: begin
                    y_nxt    = {y[WIDTH-2:0], y[WIDTH-1]};
                    is_shift = 1'b1;
                end
                MODE_ROTR: begin
                    y_nxt    = {y[0], y[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
`endif
                MODE_CLEAR: begin
                    y_nxt   = '0;
                    cnt_nxt = '0;
                end
                default: ;
            endcase
        end
        // Counter saturates at WIDTH; only the step into WIDTH raises done.
        if (is_shift && (cnt != CNT_MAX)) begin
            cnt_nxt  = cnt + 1'b1;
            done_nxt = (cnt == CNT_MAX - 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y    <= RST_VAL;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            y    <= y_nxt;
            cnt  <= cnt_nxt;
            done <= done_nxt;
        end
    end

endmodule
